branch_predictor: RTL and testbench

- Fetch-stage branch target buffer with 2-bit saturating direction counters.
- Each cycle it gives a combinational taken/target prediction for the fetch PC. The prediction drives next-PC selection and the hazard unit's `pred_taken` input.
- Branches resolved in the execute/memory latch train the tables.
- The block reports mispredictions; these become the hazard unit's flush/redirect request.

---
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage BTB with 2-bit saturating direction counters, trained from the EM latch.
// Define BRANCH_PREDICTOR_GSHARE_EN to move the counters into a gshare pattern table indexed by idx ^ ghr.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [63:0] pc_f,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        freeze,
  input  logic        update_en,
  input  logic [63:0] update_pc,
  input  logic        update_taken,
  input  logic [63:0] update_target,
  input  logic        update_pred_taken,
  input  logic [63:0] update_pred_target,
  output logic        mispredict,
  output logic [63:0] redirect_pc,
  output logic [31:0] mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [63:0]        r_target [ENTRIES];
  logic [31:0]        r_mis_cnt;

  logic [IDX_W-1:0] w_f_idx, w_u_idx;
  logic [TAG_W-1:0] w_f_tag, w_u_tag;
  logic             w_f_hit, w_u_hit;
  logic [1:0]       w_f_ctr;
  logic [63:0]      w_pc_f_inc;
  logic             w_train;

  function automatic logic [1:0] f_sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign w_f_idx    = pc_f[IDX_W+1:2];
  assign w_f_tag    = pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign w_u_idx    = update_pc[IDX_W+1:2];
  assign w_u_tag    = update_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_pc_f_inc = pc_f + 64'd4;
  // Gating with nRST keeps a held EM update from training or flagging while reset is low.
  assign w_train    = nRST & update_en & ~freeze;

  assign pred_taken  = w_f_hit & w_f_ctr[1];
  assign pred_target = pred_taken ? r_target[w_f_idx] : w_pc_f_inc;

  assign mispredict  = w_train & ((update_pred_taken != update_taken) |
                                  (update_taken & (update_pred_target != update_target)));
  assign redirect_pc = update_taken ? update_target : update_pc + 64'd4;
  assign mispredict_count = r_mis_cnt;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [1:0]       r_pht [ENTRIES];
  logic [IDX_W-1:0] r_ghr;
  logic [IDX_W-1:0] w_u_pidx;

  assign w_f_ctr  = r_pht[w_f_idx ^ r_ghr];
  assign w_u_pidx = w_u_idx ^ r_ghr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      r_ghr   <= '0;
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= 2'b01;
    end else if (w_train) begin
      r_pht[w_u_pidx] <= f_sat(r_pht[w_u_pidx], update_taken);
      r_ghr           <= {r_ghr[IDX_W-2:0], update_taken};
      if (!w_u_hit && update_taken) r_valid[w_u_idx] <= 1'b1;
    end
  end
`else
  logic [1:0] r_ctr [ENTRIES];

  assign w_f_ctr = r_ctr[w_f_idx];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (w_train) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= f_sat(r_ctr[w_u_idx], update_taken);
      end else if (update_taken) begin
        r_valid[w_u_idx] <= 1'b1;
        r_ctr[w_u_idx]   <= 2'b10;
      end
    end
  end
`endif

  // Tag/target need no reset: they are only observed through a set valid bit.
  always_ff @(posedge CLK) begin
    if (w_train && update_taken) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= update_target;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_mis_cnt <= '0;
    else if (mispredict && (r_mis_cnt != 32'hFFFF_FFFF))
      r_mis_cnt <= r_mis_cnt + 32'd1;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic vs. a table model.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int IDX_W   = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [63:0] pc_f;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        freeze;
  logic        update_en;
  logic [63:0] update_pc;
  logic        update_taken;
  logic [63:0] update_target;
  logic        update_pred_taken;
  logic [63:0] update_pred_target;
  logic        mispredict;
  logic [63:0] redirect_pc;
  logic [31:0] mispredict_count;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 CLK = ~CLK;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .nRST(nRST), .pc_f(pc_f), .pred_taken(pred_taken), .pred_target(pred_target),
    .freeze(freeze), .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
  );

  // Reference model: plain arrays indexed by arithmetic on the PC.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_ghr;
  logic [31:0] m_cnt;

  function automatic int f_idx(input logic [63:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int f_tag(input logic [63:0] pc);
    return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
  endfunction

  function automatic int f_cidx(input logic [63:0] pc);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return f_idx(pc) ^ m_ghr;
`else
    return f_idx(pc);
`endif
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic bit m_pt(input logic [63:0] pc);
    return m_hit(pc) && (m_ctr[f_cidx(pc)] >= 2);
  endfunction

  function automatic logic [63:0] m_ptgt(input logic [63:0] pc);
    return m_pt(pc) ? m_tgt[f_idx(pc)] : pc + 64'd4;
  endfunction

  function automatic bit m_mis();
    return (nRST === 1'b1) && update_en && !freeze &&
           ((update_pred_taken != update_taken) ||
            (update_taken && (update_pred_target != update_target)));
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 1;
      end
      m_ghr <= 0;
      m_cnt <= '0;
    end else if (update_en && !freeze) begin
      if (m_mis() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      m_ctr[f_cidx(update_pc)] <= update_taken ? ((m_ctr[f_cidx(update_pc)] < 3) ? m_ctr[f_cidx(update_pc)] + 1 : 3)
                                               : ((m_ctr[f_cidx(update_pc)] > 0) ? m_ctr[f_cidx(update_pc)] - 1 : 0);
      m_ghr <= ((m_ghr * 2) + int'(update_taken)) % ENTRIES;
      if (update_taken) begin
        m_valid[f_idx(update_pc)] <= 1'b1;
        m_tag[f_idx(update_pc)]   <= f_tag(update_pc);
        m_tgt[f_idx(update_pc)]   <= update_target;
      end
`else
      if (m_hit(update_pc)) begin
        m_ctr[f_idx(update_pc)] <= update_taken ? ((m_ctr[f_idx(update_pc)] < 3) ? m_ctr[f_idx(update_pc)] + 1 : 3)
                                                : ((m_ctr[f_idx(update_pc)] > 0) ? m_ctr[f_idx(update_pc)] - 1 : 0);
        if (update_taken) m_tgt[f_idx(update_pc)] <= update_target;
      end else if (update_taken) begin
        m_valid[f_idx(update_pc)] <= 1'b1;
        m_tag[f_idx(update_pc)]   <= f_tag(update_pc);
        m_tgt[f_idx(update_pc)]   <= update_target;
        m_ctr[f_idx(update_pc)]   <= 2;
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("pred_taken", {63'd0, pred_taken}, {63'd0, m_pt(pc_f) && (nRST === 1'b1)});
      chk("pred_target", pred_target, (nRST === 1'b1) ? m_ptgt(pc_f) : pc_f + 64'd4);
      chk("mispredict", {63'd0, mispredict}, {63'd0, m_mis()});
      chk("mispredict_count", {32'd0, mispredict_count}, {32'd0, m_cnt});
      if (update_en)
        chk("redirect_pc", redirect_pc, update_taken ? update_target : update_pc + 64'd4);
    end
  end

  task automatic nxt();
    @(posedge CLK); #1;
  endtask

  task automatic at_neg();
    @(negedge CLK); #1;
  endtask

  task automatic upd(input logic [63:0] pc, input bit tk, input logic [63:0] tgt,
                     input bit ptk, input logic [63:0] ptgt);
    update_en = 1'b1; update_pc = pc; update_taken = tk; update_target = tgt;
    update_pred_taken = ptk; update_pred_target = ptgt;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0: return 64'h1000;
      1: return 64'h1040;
      2: return 64'h1080;
      3: return 64'h1004;
      4: return 64'h2008;
      5: return 64'hFFFF_FFFF_FFFF_FFFC;
      6: return 64'h103C;
      default: return {$urandom, $urandom} & ~64'h3;
    endcase
  endfunction

  initial begin
    nRST = 1'b0; pc_f = 64'h1000; freeze = 1'b0;
    upd(64'h0, 1'b0, 64'h0, 1'b0, 64'h0); update_en = 1'b0;
    chk_on = 1'b1;
    #22 nRST = 1'b1;
    at_neg();
    chk("lit reset pred_taken", {63'd0, pred_taken}, 64'd0);
    chk("lit reset pred_target", pred_target, 64'h1004);
    chk("lit reset count", {32'd0, mispredict_count}, 64'd0);

    nxt(); upd(64'h1000, 1'b1, 64'h2000, 1'b0, 64'h1004);
    at_neg();
    chk("lit first mispredict", {63'd0, mispredict}, 64'd1);
    chk("lit first redirect", redirect_pc, 64'h2000);
    chk("lit no bypass", {63'd0, pred_taken}, 64'd0);
    nxt(); update_en = 1'b0;
    at_neg();
    chk("lit trained taken", {63'd0, pred_taken}, 64'd1);
    chk("lit trained target", pred_target, 64'h2000);

    for (int i = 0; i < 4; i++) begin
      nxt(); upd(64'h1000, 1'b1, 64'h2000, 1'b1, 64'h2000);
    end
    nxt(); upd(64'h1000, 1'b0, 64'h2000, 1'b1, 64'h2000);
    nxt(); update_en = 1'b0;
    at_neg();
    chk("lit sat after 1 NT", {63'd0, pred_taken}, 64'd1);
    nxt(); upd(64'h1000, 1'b0, 64'h2000, 1'b1, 64'h2000);
    nxt(); update_en = 1'b0;
    at_neg();
    chk("lit sat after 2 NT", {63'd0, pred_taken}, 64'd0);
    chk("lit count after sat", {32'd0, mispredict_count}, 64'd3);

    nxt(); upd(64'h1040, 1'b1, 64'h3000, 1'b0, 64'h1044);
    nxt(); update_en = 1'b0;
    at_neg();
    chk("lit alias miss", pred_target, 64'h1004);
    nxt(); pc_f = 64'h1040;
    at_neg();
    chk("lit alias new", pred_target, 64'h3000);

    nxt(); freeze = 1'b1; upd(64'h1080, 1'b1, 64'h4000, 1'b0, 64'h1084);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("lit frozen mispredict", {63'd0, mispredict}, 64'd0);
      nxt();
    end
    freeze = 1'b0;
    at_neg();
    chk("lit release pulse", {63'd0, mispredict}, 64'd1);
    nxt(); update_en = 1'b0;
    at_neg();
    chk("lit freeze count", {32'd0, mispredict_count}, 64'd5);

    nxt(); pc_f = 64'hFFFF_FFFF_FFFF_FFFC; upd(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0, 64'h0);
    at_neg();
    chk("lit wrap pred_target", pred_target, 64'h0);
    chk("lit wrap redirect", redirect_pc, 64'h0);

    nxt(); pc_f = 64'h1080; upd(64'h1080, 1'b1, 64'h5000, 1'b0, 64'h1084);
    #2 nRST = 1'b0;
    at_neg();
    chk("lit reset mispredict", {63'd0, mispredict}, 64'd0);
    chk("lit reset lookup", {63'd0, pred_taken}, 64'd0);
    chk("lit reset count mid", {32'd0, mispredict_count}, 64'd0);
    nRST = 1'b1;
    nxt(); update_en = 1'b0;
    at_neg();
    chk("lit post-reset count", {32'd0, mispredict_count}, 64'd1);

    for (int k = 0; k < 600; k++) begin
      nxt();
      nRST = ($urandom_range(99) != 0);
      pc_f = pick();
      update_en = ($urandom_range(9) < 6);
      update_pc = pick();
      update_taken = $urandom_range(1);
      update_target = ($urandom_range(1) != 0) ? pick() : 64'h2000;
      freeze = ($urandom_range(4) == 0);
      if ($urandom_range(3) != 0) begin
        update_pred_taken = m_pt(update_pc);
        update_pred_target = m_ptgt(update_pc);
      end else begin
        update_pred_taken = $urandom_range(1);
        update_pred_target = pick();
      end
    end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    begin
      logic [31:0] base;
      nxt(); nRST = 1'b0; freeze = 1'b0; update_en = 1'b0;
      nxt(); nRST = 1'b1; base = '0;
      for (int k = 0; k < 48; k++) begin
        if (k == 32) base = mispredict_count;
        upd(64'h1000, (k % 2) == 0, 64'h2000, m_pt(64'h1000), m_ptgt(64'h1000));
        nxt();
      end
      update_en = 1'b0;
      at_neg();
      chk("lit gshare converged", {32'd0, mispredict_count - base}, 64'd0);
    end
`endif

    nxt(); update_en = 1'b0; nRST = 1'b1;
    at_neg();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
